// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I control FSM: opcodes, states,
// datapath mux encodings and the DECODE dispatch helper.
package mc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL
    } state_t;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // State entered after DECODE; FETCH doubles as the "unsupported opcode" answer.
    function automatic state_t decode_target(input logic [6:0] opcode);
        state_t target;
        target = FETCH;
        case (opcode)
            OP_LOAD, OP_STORE: target = MEMADR;
            OP_RTYPE:          target = EXECR;
            OP_ITYPE:          target = EXECI;
            OP_BRANCH:         target = BEQ;
            OP_JAL:            target = JAL;
            default:           target = FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle and retired-instruction counters for the multicycle
// controller; only instantiated when MC_PERF_CNT_EN is defined.
module mc_perf_counters #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            retire,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNTW'(1);
            if (retire) begin
                instret_cnt <= instret_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing a multicycle RV32I datapath over a shared memory.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int OPW  = 7
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNTW = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           AdrSrc,
    output logic           RegWrite,
    output logic [1:0]     ResultSrc,
    output logic [1:0]     ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ImmSrc,
    output logic [1:0]     ALUOp,
    output logic           illegal_op,
    output logic           instr_retired
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt
`endif
);

    state_t     state;
    logic [6:0] opcode;

    assign opcode = 7'(op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:  state <= FETCH;
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE:   state <= decode_target(opcode);
                MEMADR:   state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem_ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                default:  state <= S_RESET;
            endcase
        end
    end

    // Strobes that complete a handshake (IRWrite, PCWrite in FETCH, the store
    // retire) must follow mem_ready in the same cycle, so decode is combinational.
    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ImmSrc        = IMM_I;
        ALUOp         = ALUOP_ADD;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_B;
                illegal_op = (decode_target(opcode) == FETCH);
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc     = RES_MEMDATA;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            MEMWRITE: begin
                mem_req       = 1'b1;
                MemWrite      = 1'b1;
                AdrSrc        = 1'b1;
                instr_retired = mem_ready;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            BEQ: begin
                ALUSrcA       = SRCA_RS1;
                ALUSrcB       = SRCB_RS2;
                ALUOp         = ALUOP_SUB;
                ResultSrc     = RES_ALUOUT;
                PCWrite       = zero;
                instr_retired = 1'b1;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MC_PERF_CNT_EN
    mc_perf_counters #(
        .CNTW(CNTW)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .retire      (instr_retired),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif

endmodule
